// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter that shares one router output port among num_req input FIFOs.
// Grants are bursts of up to burst_len packets, staged through a single output register.
module mesh_port_arbiter #(
  parameter int pckg_sz   = 40,
  parameter int num_req   = 4,
  parameter int burst_len = 4,
  localparam int gw = (num_req > 1) ? $clog2(num_req) : 1,
  localparam int cw = $clog2(burst_len + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [num_req-1:0]         pndng_i,
  input  logic [num_req*pckg_sz-1:0] data_i,
  output logic [num_req-1:0]         pop_o,
  input  logic                       full_i,
  output logic                       push_o,
  output logic [pckg_sz-1:0]         data_o,
  output logic [gw-1:0]              gnt_id_o,
  output logic                       busy_o,
  output logic                       dbg_state,
  output logic [cw-1:0]              dbg_cnt
);

  typedef enum logic {st_idle, st_serve} state_t;

  state_t              state, state_nxt;
  logic [gw-1:0]       gnt, gnt_nxt;
  logic [gw-1:0]       last, last_nxt;
  logic [cw-1:0]       cnt, cnt_nxt, cnt_inc;
  logic                out_vld;
  logic                pop;
  logic                slot_free;
  logic                sel_vld;
  logic [gw-1:0]       sel, cand;
  logic [pckg_sz-1:0]  head [num_req];

  always_comb begin
    for (int r = 0; r < num_req; r++) begin
      head[r] = data_i[r*pckg_sz +: pckg_sz];
    end
  end

  // Handshake: push_o is a valid that holds data_o stable until a cycle with
  // full_i == 0, where the packet is taken on that rising edge.
  assign slot_free = !out_vld || !full_i;
  assign cnt_inc   = cnt + cw'(1);

  // Rotating priority: the requester just after the last granted one wins.
  always_comb begin
    sel_vld = 1'b0;
    sel     = last;
    cand    = last;
    for (int i = 1; i <= num_req; i++) begin
      cand = gw'((int'(last) + i) % num_req);
      if (!sel_vld && pndng_i[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      st_idle: begin
        if (sel_vld) begin
          state_nxt = st_serve;
          gnt_nxt   = sel;
          cnt_nxt   = '0;
        end
      end
      st_serve: begin
        if (!pndng_i[gnt]) begin
          state_nxt = st_idle;
          last_nxt  = gnt;
        end else if (slot_free) begin
          pop     = 1'b1;
          cnt_nxt = cnt_inc;
          if (cnt_inc == cw'(burst_len)) begin
            state_nxt = st_idle;
            last_nxt  = gnt;
          end
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  // The reset term keeps the FIFOs untouched while the arbiter is held in reset.
  always_comb begin
    pop_o      = '0;
    pop_o[gnt] = pop && reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= st_idle;
      gnt   <= gw'(num_req - 1);
      last  <= gw'(num_req - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A pop refills the register in the same edge the old packet drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
      data_o  <= '0;
    end else if (pop) begin
      out_vld <= 1'b1;
      data_o  <= head[gnt];
    end else if (!full_i) begin
      out_vld <= 1'b0;
    end
  end

  assign push_o    = out_vld;
  assign gnt_id_o  = gnt;
  assign busy_o    = (state == st_serve);
  assign dbg_state = (state == st_serve);
  assign dbg_cnt   = cnt;

endmodule
